// File: rtl/dma_tcdm_rd_burst.sv
// ---------------------------------------------------------------------------
// dma_tcdm_rd_burst
//
// Turns one AXI INCR read burst from the DMA crossbar into per-bank TCDM word
// reads. Every DATA_WIDTH beat is split into NB_BANKS 32-bit lane reads. Each
// lane issues, buffers and returns its words independently. A whole R beat is
// presented once every lane holds a word.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   ar_*                    AXI read address channel (one burst at a time)
//   r_*                     AXI read data channel (data, id, resp, last)
//   tcdm_req_o/gnt_i        per-lane request / grant handshake
//   tcdm_add_o              per-lane word byte address, lane k at [32k+:32]
//   tcdm_wen_o, tcdm_be_o   constant read / all-bytes
//   tcdm_r_valid_i/rdata_i  per-lane response, exactly one cycle after grant
//   busy_o                  a burst is in progress
// ---------------------------------------------------------------------------
module dma_tcdm_rd_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]     ar_addr_i,
  input  logic [ID_WIDTH-1:0]       ar_id_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [DATA_WIDTH-1:0]     r_data_o,
  output logic [ID_WIDTH-1:0]       r_id_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [DATA_WIDTH/32-1:0]  tcdm_req_o,
  input  logic [DATA_WIDTH/32-1:0]  tcdm_gnt_i,
  output logic [DATA_WIDTH-1:0]     tcdm_add_o,
  output logic [DATA_WIDTH/32-1:0]  tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0]   tcdm_be_o,
  input  logic [DATA_WIDTH/32-1:0]  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]     tcdm_r_rdata_i,
  output logic                      busy_o
);

  localparam int NB_BANKS   = DATA_WIDTH / 32;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int SIZE_LOG2  = $clog2(BEAT_BYTES);
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            rcnt_q, rcnt_d;
  logic                  err_q, err_d;

  logic                  ar_hs;
  logic                  pop;
  logic [NB_BANKS-1:0]   lane_nempty;
  logic [DATA_WIDTH-1:0] head_data;

  assign ar_ready_o = (state_q == IDLE);
  assign ar_hs      = ar_valid_i & ar_ready_o;
  assign busy_o     = (state_q == BURST);
  // Error bursts never touch the lanes, so they produce beats on their own.
  assign r_valid_o  = busy_o & (err_q | (&lane_nempty));
  assign r_last_o   = r_valid_o & (rcnt_q == beats_q - 9'd1);
  assign pop        = r_valid_o & r_ready_i;
  assign r_data_o   = err_q ? '0 : head_data;
  assign r_resp_o   = err_q ? 2'b10 : 2'b00;
  assign r_id_o     = id_q;
  assign tcdm_wen_o = '1;
  assign tcdm_be_o  = '1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    id_d    = id_q;
    beats_d = beats_q;
    err_d   = err_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = BURST;
          base_d  = ar_addr_i & ~ADDR_WIDTH'(BEAT_BYTES - 1);
          id_d    = ar_id_i;
          beats_d = {1'b0, ar_len_i} + 9'd1;
          err_d   = (ar_size_i != 3'(SIZE_LOG2));
          rcnt_d  = '0;
        end
      end
      BURST: begin
        if (pop) begin
          rcnt_d = rcnt_q + 9'd1;
          if (r_last_o) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beats_q <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    base_q <= base_d;
    id_q   <= id_d;
  end

  for (genvar k = 0; k < NB_BANKS; k++) begin : g_lane
    logic [8:0]            iss_q, iss_d;
    logic [CNT_W-1:0]      cred_q, cred_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [31:0]           buf_q [BUF_DEPTH];
    logic                  lpop, push, req, gnt;
    logic [ADDR_WIDTH-1:0] addr;

    assign lpop = pop & ~err_q;
    assign push = tcdm_r_valid_i[k];
    // Credit covers buffered plus in-flight words. A word leaving this cycle
    // frees its slot immediately so a full lane can still stream one word per
    // cycle; the request then stays up until granted because the pop lowers
    // the count at the same edge.
    assign req  = busy_o & ~err_q & ~rst_i & (iss_q != beats_q) &
                  ((cred_q < DEPTH_C) | lpop);
    assign gnt  = req & tcdm_gnt_i[k];
    assign addr = base_q + ADDR_WIDTH'({iss_q, {SIZE_LOG2{1'b0}}}) + ADDR_WIDTH'(4 * k);

    assign tcdm_req_o[k]            = req;
    assign tcdm_add_o[32*k +: 32]   = 32'(addr);
    assign lane_nempty[k]           = (fill_q != '0);
    assign head_data[32*k +: 32]    = buf_q[rptr_q];

    always_comb begin
      iss_d  = iss_q;
      cred_d = cred_q;
      fill_d = fill_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (ar_hs)    iss_d = '0;
      else if (gnt) iss_d = iss_q + 9'd1;
      if (gnt & ~lpop)      cred_d = cred_q + CNT_W'(1);
      else if (~gnt & lpop) cred_d = cred_q - CNT_W'(1);
      if (push & ~lpop)      fill_d = fill_q + CNT_W'(1);
      else if (~push & lpop) fill_d = fill_q - CNT_W'(1);
      if (push) wptr_d = ptr_inc(wptr_q);
      if (lpop) rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        iss_q  <= '0;
        cred_q <= '0;
        fill_q <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        iss_q  <= iss_d;
        cred_q <= cred_d;
        fill_q <= fill_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    // Storage is not reset: the pointers and fill count decide what is live.
    always_ff @(posedge clk_i) begin
      if (push) buf_q[wptr_q] <= tcdm_r_rdata_i[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_dma_tcdm_rd_burst.sv
module tb_dma_tcdm_rd_burst;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int BD = 2;
  localparam int NB = DW / 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ar_valid_i;
  logic          ar_ready_o;
  logic [AW-1:0] ar_addr_i;
  logic [IW-1:0] ar_id_i;
  logic [7:0]    ar_len_i;
  logic [2:0]    ar_size_i;
  logic          r_valid_o;
  logic          r_ready_i;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic [1:0]    r_resp_o;
  logic          r_last_o;
  logic [NB-1:0] tcdm_req_o;
  logic [NB-1:0] tcdm_gnt_i;
  logic [DW-1:0] tcdm_add_o;
  logic [NB-1:0] tcdm_wen_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [NB-1:0] tcdm_r_valid_i;
  logic [DW-1:0] tcdm_r_rdata_i;
  logic          busy_o;

  always #5 clk = ~clk;

  dma_tcdm_rd_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BUF_DEPTH(BD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc_n = 0;
  int            gnt_stall [NB];
  int            lane_iss [NB];
  int            out_cnt [NB];
  logic [31:0]   lane_base = '0;
  bit            rr_toggle = 1'b0;
  logic [NB-1:0] pend_v = '0;
  logic [DW-1:0] pend_d = '0;
  bit            ar_hs = 1'b0;
  int            req_seen = 0;
  int            beats_got = 0;
  int            first_beat_cyc = 0;
  int            last_beat_cyc = 0;
  int            ar_cyc = 0;
  bit            hold_chk = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // return just after the rising edge so callers change inputs for the next cycle.
  task automatic cyc();
    logic [31:0] a;
    logic [31:0] ea;
    beat_t       e;
    @(negedge clk);
    cyc_n++;
    tcdm_r_valid_i = pend_v;
    tcdm_r_rdata_i = pend_d;
    for (int k = 0; k < NB; k++) begin
      tcdm_gnt_i[k] = (gnt_stall[k] == 0);
      if (gnt_stall[k] > 0) gnt_stall[k]--;
    end
    r_ready_i = rr_toggle ? ~r_ready_i : 1'b1;
    #1;
    if (hold_chk) begin
      chk("hold_valid", 64'(r_valid_o), 64'd1);
      chk("hold_data", r_data_o, hold_data);
      chk("hold_last", 64'(r_last_o), 64'(hold_last));
    end
    hold_chk = 1'b0;
    ar_hs = ar_valid_i && ar_ready_o;
    if (r_valid_o && r_ready_i) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("r_data", r_data_o, e.data);
        chk("r_id", 64'(r_id_o), 64'(e.id));
        chk("r_resp", 64'(r_resp_o), 64'(e.resp));
        chk("r_last", 64'(r_last_o), 64'(e.last));
        if (e.resp == 2'b00)
          for (int k = 0; k < NB; k++) out_cnt[k]--;
        beats_got++;
        if (beats_got == 1) first_beat_cyc = cyc_n;
        last_beat_cyc = cyc_n;
      end
    end else if (r_valid_o) begin
      hold_chk  = 1'b1;
      hold_data = r_data_o;
      hold_last = r_last_o;
    end
    pend_v = '0;
    for (int k = 0; k < NB; k++) begin
      if (tcdm_req_o[k] === 1'b1) req_seen++;
      if (tcdm_req_o[k] === 1'b1 && tcdm_gnt_i[k]) begin
        a  = tcdm_add_o[32*k +: 32];
        ea = lane_base + 32'(lane_iss[k] * 8 + 4 * k);
        chk("tcdm_add", 64'(a), 64'(ea));
        pend_v[k] = 1'b1;
        pend_d[32*k +: 32] = mem_word(a);
        lane_iss[k]++;
        out_cnt[k]++;
        chk("lane_credit_le_depth", 64'(out_cnt[k] <= BD), 64'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [3:0] id, output int waits);
    beat_t       e;
    logic [31:0] w0;
    int          L;
    ar_addr_i = a; ar_len_i = len; ar_size_i = sz; ar_id_i = id; ar_valid_i = 1'b1;
    waits = 0;
    ar_hs = 1'b0;
    while (!ar_hs && waits < 20) begin
      cyc();
      waits++;
    end
    ar_valid_i = 1'b0;
    chk("ar_accept", 64'(ar_hs), 64'd1);
    if (ar_hs) begin
      ar_cyc    = cyc_n;
      beats_got = 0;
      lane_base = a & ~32'h7;
      for (int k = 0; k < NB; k++) lane_iss[k] = 0;
      L = int'(len);
      for (int b = 0; b <= L; b++) begin
        e.id   = id;
        e.last = (b == L);
        if (sz != 3'd3) begin
          e.data = '0;
          e.resp = 2'b10;
        end else begin
          w0     = lane_base + 32'(b * 8);
          e.data = {mem_word(w0 + 32'd4), mem_word(w0)};
          e.resp = 2'b00;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ar_ready"}, 64'(ar_ready_o), 64'd1);
    chk({tag, "_r_valid"}, 64'(r_valid_o), 64'd0);
    chk({tag, "_r_last"}, 64'(r_last_o), 64'd0);
    chk({tag, "_req"}, 64'(tcdm_req_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int w;
    int n;
    rst_i = 1'b1; ar_valid_i = 1'b0; ar_addr_i = '0; ar_id_i = '0; ar_len_i = '0;
    ar_size_i = 3'd3; r_ready_i = 1'b1; tcdm_gnt_i = '0; tcdm_r_valid_i = '0;
    tcdm_r_rdata_i = '0;
    for (int k = 0; k < NB; k++) begin
      gnt_stall[k] = 0; lane_iss[k] = 0; out_cnt[k] = 0;
    end
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
    check_idle("reset");
    chk("wen_const", 64'(tcdm_wen_o), 64'h3);
    chk("be_const", 64'(tcdm_be_o), 64'hFF);

    // Basic aligned burst, full throughput.
    send_ar(32'h100, 8'd3, 3'd3, 4'h5, w);
    drain(40);
    chk("t1_beats", 64'(beats_got), 64'd4);
    chk("t1_latency", 64'(first_beat_cyc - ar_cyc), 64'd3);
    chk("t1_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 64'd3);
    chk("t1_busy_after", 64'(busy_o), 64'd0);
    cyc();
    cyc();

    // Lane 1 grant withheld: lane 0 must stop at its credit limit.
    gnt_stall[1] = 8;
    send_ar(32'h100, 8'd3, 3'd3, 4'h6, w);
    for (int i = 0; i < 4; i++) cyc();
    chk("t2_lane0_issued", 64'(lane_iss[0]), 64'(BD));
    chk("t2_lane1_issued", 64'(lane_iss[1]), 64'd0);
    chk("t2_no_beat_yet", 64'(beats_got), 64'd0);
    drain(60);
    chk("t2_beats", 64'(beats_got), 64'd4);
    cyc();

    // Backpressure on R.
    rr_toggle = 1'b1;
    send_ar(32'h400, 8'd7, 3'd3, 4'h9, w);
    drain(200);
    chk("t3_beats", 64'(beats_got), 64'd8);
    rr_toggle = 1'b0;
    cyc();

    // Wrong size: error beats, no TCDM traffic.
    req_seen = 0;
    send_ar(32'h500, 8'd1, 3'd2, 4'hA, w);
    drain(40);
    chk("t4_beats", 64'(beats_got), 64'd2);
    chk("t4_no_req", 64'(req_seen), 64'd0);
    cyc();

    // Reset in the middle of a long burst.
    send_ar(32'h40, 8'd15, 3'd3, 4'h3, w);
    n = 0;
    while (beats_got < 2 && n < 50) begin
      cyc();
      n++;
    end
    chk("t5_reached_beat2", 64'(beats_got), 64'd2);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    exp_q.delete();
    hold_chk = 1'b0;
    for (int k = 0; k < NB; k++) begin
      out_cnt[k] = 0; lane_iss[k] = 0;
    end
    #1;
    check_idle("mid_rst");
    send_ar(32'h200, 8'd0, 3'd3, 4'hC, w);
    drain(40);
    chk("t5_beats", 64'(beats_got), 64'd1);
    for (int i = 0; i < 4; i++) cyc();

    // Unaligned start, then an immediate follow-on burst.
    send_ar(32'h7, 8'd0, 3'd3, 4'h1, w);
    drain(40);
    send_ar(32'h10, 8'd0, 3'd3, 4'h2, w);
    chk("t6_b2b_accept_wait", 64'(w), 64'd1);
    drain(40);
    for (int i = 0; i < 3; i++) cyc();
    chk("t6_idle_busy", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
